hour_counter_bcd: RTL and testbench

- Parametrised hour-digit counter for the watch controller; replaces the fixed mod-13 first-digit counter.
- Keeps one binary hour count, 0..FULL-1. Outputs two BCD display digits, an AM/PM flag and a wrap carry.
- Runtime-selectable 24h or 12h display; the internal count is unchanged when the mode toggles.
- Sits between the minute counter (its cout drives tick here) and the 7-segment decoder.

---
 rtl/hour_counter_bcd.sv | 128 ++++++++++++
 tb/tb_hour_counter_bcd.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hour_counter_bcd.sv
// Binary hour counter with BCD display decode, 12h/24h selectable view.
// Define HOUR_DOWN_EN to add the dir input and borrow output for down-counting.
module hour_counter_bcd #(
  parameter int FULL  = 24,
  parameter int HALF  = 12,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start_resume,
  input  logic             stop,
  input  logic             clear,
  input  logic             set,
  input  logic [WIDTH-1:0] init,
  input  logic             mode_24,
`ifdef HOUR_DOWN_EN
  input  logic             dir,
  output logic             borrow,
`endif
  output logic [WIDTH-1:0] count,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             pm,
  output logic             cout,
  output logic             set_err
);

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(FULL - 1);
  localparam logic [WIDTH-1:0] HALF_W = WIDTH'(HALF);
  localparam logic [6:0]       HALF_7 = 7'(HALF);

  logic [WIDTH-1:0] count_q, count_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;
  logic             run;
`ifdef HOUR_DOWN_EN
  logic             borrow_q, borrow_d;
`endif

  assign run = start_resume & ~stop;

  always_comb begin
    count_d = count_q;
    cout_d  = 1'b0;
    err_d   = 1'b0;
`ifdef HOUR_DOWN_EN
    borrow_d = 1'b0;
`endif
    if (set) begin
      if (init > MAX_W) err_d = 1'b1;
      else              count_d = init;
    end else if (clear) begin
      count_d = '0;
    end else if (run && tick) begin
`ifdef HOUR_DOWN_EN
      if (dir) begin
        if (count_q == '0) begin
          count_d  = MAX_W;
          borrow_d = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end else
`endif
      if (count_q == MAX_W) begin
        count_d = '0;
        cout_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef HOUR_DOWN_EN
      borrow_q <= 1'b0;
`endif
    end else begin
      count_q <= count_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
`ifdef HOUR_DOWN_EN
      borrow_q <= borrow_d;
`endif
    end
  end

  // Display decode: fold to 1..HALF in 12h view, then repeated
  // subtract-by-ten for the BCD split (count never exceeds 99).
  logic [6:0] cnt7;
  logic [6:0] disp;
  logic [6:0] rem;
  logic [3:0] tens_v;

  assign cnt7 = 7'(count_q);

  always_comb begin
    disp = cnt7;
    if (!mode_24) begin
      if (cnt7 >= HALF_7) disp = cnt7 - HALF_7;
      if (disp == 7'd0)   disp = HALF_7;
    end
    rem    = disp;
    tens_v = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (rem >= 7'd10) begin
        rem    = rem - 7'd10;
        tens_v = tens_v + 4'd1;
      end
    end
  end

  assign count   = count_q;
  assign tens    = tens_v;
  assign ones    = 4'(rem);
  assign pm      = (count_q >= HALF_W);
  assign cout    = cout_q;
  assign set_err = err_q;
`ifdef HOUR_DOWN_EN
  assign borrow  = borrow_q;
`endif

endmodule

// File: tb/tb_hour_counter_bcd.sv
// Self-checking bench for hour_counter_bcd: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_hour_counter_bcd;

  localparam int FULL = 24;
  localparam int HALF = 12;
  localparam int W    = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick, start_resume, stop, clear, set, mode_24;
  logic [W-1:0] init;
  logic         dir;
  logic         borrow;
  logic [W-1:0] count;
  logic [3:0]   tens, ones;
  logic         pm, cout, set_err;

  int errors = 0;
  int checks = 0;

  int m_cnt = 0;
  bit m_cout = 0;
  bit m_err = 0;
  bit m_bor = 0;

  always #5 clk = ~clk;

  hour_counter_bcd #(.FULL(FULL), .HALF(HALF), .WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .start_resume(start_resume),
    .stop(stop),
    .clear(clear),
    .set(set),
    .init(init),
    .mode_24(mode_24),
`ifdef HOUR_DOWN_EN
    .dir(dir),
    .borrow(borrow),
`endif
    .count(count),
    .tens(tens),
    .ones(ones),
    .pm(pm),
    .cout(cout),
    .set_err(set_err)
  );

`ifndef HOUR_DOWN_EN
  assign borrow = 1'b0;
`endif

  function automatic int disp(int c, bit m24);
    int d;
    if (m24) return c;
    d = c % HALF;
    return (d == 0) ? HALF : d;
  endfunction

  // Drive one edge worth of inputs and advance the reference model.
  task automatic apply(input bit s, input bit c, input bit t,
                       input bit sr, input bit sp, input int ini,
                       input bit dr);
    set = s; clear = c; tick = t;
    start_resume = sr; stop = sp;
    init = W'(ini); dir = dr;
    @(posedge clk);
    m_cout = 0; m_err = 0; m_bor = 0;
    if (s) begin
      if (ini < FULL) m_cnt = ini;
      else m_err = 1;
    end else if (c) begin
      m_cnt = 0;
    end else if (t && sr && !sp) begin
`ifdef HOUR_DOWN_EN
      if (dr) begin
        m_bor = (m_cnt == 0);
        m_cnt = (m_cnt + FULL - 1) % FULL;
      end else
`endif
      begin
        m_cnt = (m_cnt + 1) % FULL;
        m_cout = (m_cnt == 0);
      end
    end
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 0, 0, 17, 0);
    checks++;
    if (count !== 5'd17) begin
      errors++;
      $display("FAIL preload count=%0d want 17", count);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || cout !== 1'b0 || set_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset count=%0d cout=%b err=%b want 0/0/0",
               count, cout, set_err);
    end
    #1 reset = 1'b1;
    m_cnt = 0; m_cout = 0; m_err = 0; m_bor = 0;
    mode_24 = 1'b1;
    #1;
    checks++;
    if (tens !== 4'd0 || ones !== 4'd0 || pm !== 1'b0) begin
      errors++;
      $display("FAIL reset_decode tens=%0d ones=%0d pm=%b want 0/0/0",
               tens, ones, pm);
    end
  endtask

  task automatic test_wrap();
    mode_24 = 1'b1;
    apply(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 24; k++) begin
      apply(0, 0, 1, 1, 0, 0, 0);
      checks++;
      if (count !== W'((k + 1) % FULL) || cout !== (k == 23)) begin
        errors++;
        $display("FAIL wrap_step%0d count=%0d cout=%b want %0d/%b",
                 k, count, cout, (k + 1) % FULL, k == 23);
      end
      if (k == 22) begin
        checks++;
        if (tens !== 4'd2 || ones !== 4'd3 || pm !== 1'b1) begin
          errors++;
          $display("FAIL decode23 tens=%0d ones=%0d pm=%b want 2/3/1",
                   tens, ones, pm);
        end
      end
    end
  endtask

  task automatic test_12h();
    int vals[6] = '{0, 1, 11, 12, 13, 23};
    int shown[6] = '{12, 1, 11, 12, 1, 11};
    bit pms[6] = '{0, 0, 0, 1, 1, 1};
    mode_24 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      apply(1, 0, 0, 0, 0, vals[i], 0);
      checks++;
      if (tens !== 4'(shown[i] / 10) || ones !== 4'(shown[i] % 10) ||
          pm !== pms[i]) begin
        errors++;
        $display("FAIL h12_%0d shown=%0d%0d pm=%b want %0d pm=%b",
                 vals[i], tens, ones, pm, shown[i], pms[i]);
      end
    end
    apply(1, 0, 0, 0, 0, 15, 0);
    mode_24 = 1'b1;
    #1;
    checks++;
    if (tens !== 4'd1 || ones !== 4'd5 || count !== 5'd15) begin
      errors++;
      $display("FAIL toggle24 shown=%0d%0d count=%0d want 15/15",
               tens, ones, count);
    end
    mode_24 = 1'b0;
    #1;
    checks++;
    if (tens !== 4'd0 || ones !== 4'd3 || count !== 5'd15 || pm !== 1'b1) begin
      errors++;
      $display("FAIL toggle12 shown=%0d%0d count=%0d pm=%b want 03/15/1",
               tens, ones, count, pm);
    end
    mode_24 = 1'b1;
  endtask

  task automatic test_priority();
    apply(1, 0, 0, 0, 0, 23, 0);
    apply(1, 1, 1, 1, 0, 9, 0);
    checks++;
    if (count !== 5'd9 || cout !== 1'b0) begin
      errors++;
      $display("FAIL set_over_all count=%0d cout=%b want 9/0", count, cout);
    end
    for (int i = 0; i < 3; i++) apply(0, 0, 1, 1, 1, 0, 0);
    checks++;
    if (count !== 5'd9) begin
      errors++;
      $display("FAIL stop_hold count=%0d want 9", count);
    end
    for (int i = 0; i < 3; i++) apply(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (count !== 5'd9) begin
      errors++;
      $display("FAIL idle_drop count=%0d want 9", count);
    end
    apply(0, 1, 1, 1, 0, 0, 0);
    checks++;
    if (count !== 5'd0) begin
      errors++;
      $display("FAIL clear_over_tick count=%0d want 0", count);
    end
  endtask

  task automatic test_illegal_set();
    apply(1, 0, 0, 0, 0, 7, 0);
    apply(1, 0, 0, 0, 0, 25, 0);
    checks++;
    if (count !== 5'd7 || set_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_set count=%0d err=%b want 7/1", count, set_err);
    end
    idle();
    checks++;
    if (set_err !== 1'b0 || count !== 5'd7) begin
      errors++;
      $display("FAIL err_pulse err=%b count=%0d want 0/7", set_err, count);
    end
    apply(1, 0, 0, 0, 0, 23, 0);
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (count !== 5'd0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL set_zero count=%0d cout=%b want 0/0", count, cout);
    end
  endtask

`ifdef HOUR_DOWN_EN
  task automatic test_down();
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 1, 0, 0, 1);
    checks++;
    if (count !== 5'd23 || borrow !== 1'b1 || cout !== 1'b0) begin
      errors++;
      $display("FAIL down_wrap count=%0d borrow=%b cout=%b want 23/1/0",
               count, borrow, cout);
    end
    idle();
    checks++;
    if (borrow !== 1'b0) begin
      errors++;
      $display("FAIL borrow_pulse borrow=%b want 0", borrow);
    end
    apply(1, 0, 0, 0, 0, 12, 0);
    apply(0, 0, 1, 1, 0, 0, 1);
    checks++;
    if (count !== 5'd11 || pm !== 1'b0) begin
      errors++;
      $display("FAIL down_pm count=%0d pm=%b want 11/0", count, pm);
    end
  endtask
`endif

  task automatic test_random();
    int d;
    for (int i = 0; i < 400; i++) begin
      mode_24 = 1'($urandom_range(0, 1));
      apply($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 31),
            1'($urandom_range(0, 1)));
      d = disp(m_cnt, mode_24);
      checks++;
      if (count !== W'(m_cnt) || cout !== m_cout || set_err !== m_err ||
          borrow !== m_bor) begin
        errors++;
        $display("FAIL rand%0d count=%0d cout=%b err=%b bor=%b want %0d/%b/%b/%b",
                 i, count, cout, set_err, borrow, m_cnt, m_cout, m_err, m_bor);
      end
      checks++;
      if (tens !== 4'(d / 10) || ones !== 4'(d % 10) ||
          pm !== (m_cnt >= HALF)) begin
        errors++;
        $display("FAIL rand_disp%0d shown=%0d%0d pm=%b want %0d pm=%b",
                 i, tens, ones, pm, d, m_cnt >= HALF);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    tick = 0; start_resume = 0; stop = 0;
    clear = 0; set = 0; init = '0;
    mode_24 = 1'b1; dir = 1'b0;
    #12 reset = 1'b1;
    test_reset();
    test_wrap();
    test_12h();
    test_priority();
    test_illegal_set();
`ifdef HOUR_DOWN_EN
    test_down();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
